// File: rtl/multiface_ctl_if.sv
// CPU-side bus bundle between the motherboard Z80 bus and the Multiface freezer controller.
interface multiface_ctl_if #(
    parameter int RAM_AW = 13
);
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_dout;
    logic              m1;
    logic              io_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic [RAM_AW-1:0] ram_a;
    logic              key_nmi;
    logic              nmi;
    logic              mf_rom_en;
    logic              mf_ram_en;
    logic [7:0]        dout;
    logic [2:0]        state;

    modport master (
        output cpu_addr, cpu_dout, m1, io_wr, mem_rd, mem_wr, ram_a, key_nmi,
        input  nmi, mf_rom_en, mf_ram_en, dout, state
    );

    modport slave (
        input  cpu_addr, cpu_dout, m1, io_wr, mem_rd, mem_wr, ram_a, key_nmi,
        output nmi, mf_rom_en, mf_ram_en, dout, state
    );
endinterface

// File: rtl/multiface_ctl.sv
// Multiface freezer controller: hotkey to NMI, ROM/RAM paging over the low 16 KB,
// and shadowing of write-only CPC hardware registers into the internal RAM.
module multiface_ctl #(
    parameter int          RAM_AW      = 13,
    parameter int          CRTC_REGS   = 16,
    parameter logic [15:0] CTRL_PORT   = 16'hFEE8,
    parameter int          NMI_TIMEOUT = 0
) (
    input  logic          clk_sys,
    input  logic          reset,
    multiface_ctl_if.slave bus
);
    localparam int                TW       = (NMI_TIMEOUT > 0) ? $clog2(NMI_TIMEOUT + 1) : 1;
    localparam logic [RAM_AW-1:0] TOP_BASE = ~RAM_AW'(13'h1FFF);
    localparam logic [4:0]        IDX_MASK = (CRTC_REGS == 32) ? 5'h1F : 5'h0F;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PEND      = 3'd1,
        S_PAGED     = 3'd2,
        S_UNPAGED   = 3'd3,
        S_HID_PAGED = 3'd4,
        S_HIDDEN    = 3'd5
    } state_t;

    state_t            r_state, w_state_next;
    state_t            r_entry, w_entry_next;
    logic [TW-1:0]     r_tmo_cnt, w_tmo_next;
    logic              r_key_q, r_key_qq, r_m1_q, r_m1_qq, r_io_q, r_io_qq;
    logic [15:0]       r_addr_q;
    logic [7:0]        r_data_q;
    logic [4:0]        r_pen, w_pen_next;
    logic [4:0]        r_crtc_idx, w_crtc_next;
    logic              r_we, w_we;
    logic [RAM_AW-1:0] r_waddr, w_waddr;
    logic [7:0]        r_wdata, w_wdata;
    logic [7:0]        r_rdata;
    logic [7:0]        r_mem [2**RAM_AW];

    logic              w_key_rise, w_m1_rise, w_io_rise, w_ctrl_hit, w_tmo_hit;
    logic              w_paged, w_shadow_hit;
    logic [12:0]       w_shadow_off;

    // Strobes and the address/data that accompany them are sampled together, so
    // every decision below sees a coherent snapshot of the bus cycle.
    assign w_key_rise = r_key_q & ~r_key_qq;
    assign w_m1_rise  = r_m1_q & ~r_m1_qq;
    assign w_io_rise  = r_io_q & ~r_io_qq;
    assign w_ctrl_hit = w_io_rise && (r_addr_q[15:2] == CTRL_PORT[15:2]);
    assign w_tmo_hit  = (NMI_TIMEOUT > 0) && (r_tmo_cnt == TW'(NMI_TIMEOUT));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_entry   <= S_IDLE;
            r_tmo_cnt <= '0;
        end else begin
            // NOTE: all state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state   <= w_state_next;
            r_entry   <= w_entry_next;
            r_tmo_cnt <= w_tmo_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        w_state_next = r_state;
        w_entry_next = r_entry;
        w_tmo_next   = '0;
        case (r_state)
            S_IDLE, S_UNPAGED, S_HIDDEN: begin
                if (r_state == S_UNPAGED && w_ctrl_hit && !r_addr_q[1]) begin
                    w_state_next = S_PAGED;
                end else if (w_key_rise) begin
                    w_state_next = S_PEND;
                    w_entry_next = r_state;
                end
            end
            S_PEND: begin
                if (w_m1_rise && r_addr_q == 16'h0066) begin
                    w_state_next = S_PAGED;
                end else if (w_tmo_hit) begin
                    w_state_next = r_entry;
                end else if (NMI_TIMEOUT > 0) begin
                    w_tmo_next = r_tmo_cnt + 1'b1;
                end
            end
            S_PAGED: begin
                if (w_ctrl_hit) begin
                    w_state_next = r_addr_q[1] ? S_UNPAGED : S_PAGED;
                end else if (w_m1_rise && r_addr_q == 16'h0065) begin
                    w_state_next = S_HID_PAGED;
                end
            end
            S_HID_PAGED: begin
                if (w_ctrl_hit) begin
                    w_state_next = S_HIDDEN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_shadow_hit = 1'b0;
        w_shadow_off = '0;
        w_pen_next   = r_pen;
        w_crtc_next  = r_crtc_idx;
        if (w_io_rise && !w_ctrl_hit) begin
            case (r_addr_q[15:8])
                8'h7F: begin
                    w_shadow_hit = 1'b1;
                    case (r_data_q[7:6])
                        2'b00: begin
                            w_shadow_off = 13'h1FCF;
                            w_pen_next   = r_data_q[4:0];
                        end
                        2'b01:   w_shadow_off = r_pen[4] ? 13'h1FDF : 13'h1F90 + 13'(r_pen[3:0]);
                        2'b10:   w_shadow_off = 13'h1FEF;
                        default: w_shadow_off = 13'h1FFF;
                    endcase
                end
                8'hBC: begin
                    w_shadow_hit = 1'b1;
                    w_shadow_off = 13'h1CFF;
                    w_crtc_next  = r_data_q[4:0] & IDX_MASK;
                end
                8'hBD: begin
                    w_shadow_hit = 1'b1;
                    w_shadow_off = 13'h1DB0 + 13'(r_crtc_idx);
                end
                8'hF7: begin
                    w_shadow_hit = 1'b1;
                    w_shadow_off = 13'h17FF;
                end
                8'hDF: begin
                    w_shadow_hit = 1'b1;
                    w_shadow_off = 13'h1AAC;
                end
                default: ;
            endcase
        end
    end

    // Shadow capture owns the RAM port over a same-cycle CPU write.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.ram_a;
        w_wdata = bus.cpu_dout;
        if (w_shadow_hit) begin
            w_we    = 1'b1;
            w_waddr = TOP_BASE | RAM_AW'(w_shadow_off);
            w_wdata = r_data_q;
        end else if (bus.mf_ram_en && bus.mem_wr) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_key_q    <= 1'b0;
            r_key_qq   <= 1'b0;
            r_m1_q     <= 1'b0;
            r_m1_qq    <= 1'b0;
            r_io_q     <= 1'b0;
            r_io_qq    <= 1'b0;
            r_addr_q   <= '0;
            r_data_q   <= '0;
            r_pen      <= '0;
            r_crtc_idx <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_key_q    <= bus.key_nmi;
            r_key_qq   <= r_key_q;
            r_m1_q     <= bus.m1;
            r_m1_qq    <= r_m1_q;
            r_io_q     <= bus.io_wr;
            r_io_qq    <= r_io_q;
            r_addr_q   <= bus.cpu_addr;
            r_data_q   <= bus.cpu_dout;
            r_pen      <= w_pen_next;
            r_crtc_idx <= w_crtc_next;
            r_we       <= w_we;
            r_waddr    <= w_waddr;
            r_wdata    <= w_wdata;
        end
    end

    // NOTE: the RAM array and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk_sys) begin
        if (r_we) begin
            r_mem[r_waddr] <= r_wdata;
        end
        r_rdata <= (r_we && r_waddr == bus.ram_a) ? r_wdata : r_mem[bus.ram_a];
    end

    assign w_paged       = (r_state == S_PAGED) || (r_state == S_HID_PAGED);
    assign bus.nmi       = (r_state == S_PEND);
    assign bus.mf_rom_en = w_paged && (bus.cpu_addr[15:13] == 3'd0);
    assign bus.mf_ram_en = w_paged && (bus.cpu_addr[15:13] == 3'd1);
    assign bus.dout      = (bus.mf_ram_en && bus.mem_rd) ? r_rdata : 8'hFF;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_multiface_ctl.sv
// Directed bench for multiface_ctl: paging FSM, NMI timeout, RAM and shadow capture,
// with RAM read expectations queued at issue and compared when dout is valid.
module tb_multiface_ctl;
    localparam int RAM_AW = 13;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multiface_ctl_if #(.RAM_AW(RAM_AW)) bus ();

    multiface_ctl #(
        .RAM_AW     (RAM_AW),
        .CRTC_REGS  (16),
        .CTRL_PORT  (16'hFEE8),
        .NMI_TIMEOUT(100)
    ) dut (
        .clk_sys(clk),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    int      n_vec  = 0;
    int      n_fail = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic key_pulse();
        bus.key_nmi = 1'b1;
        tick(1);
        bus.key_nmi = 1'b0;
        tick(1);
    endtask

    task automatic fetch(input logic [15:0] a);
        bus.cpu_addr = a;
        bus.m1       = 1'b1;
        tick(1);
        bus.m1 = 1'b0;
        tick(1);
    endtask

    task automatic io_out(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_addr = a;
        bus.cpu_dout = d;
        bus.io_wr    = 1'b1;
        tick(1);
        bus.io_wr = 1'b0;
        tick(3);
    endtask

    task automatic ram_write(input logic [RAM_AW-1:0] ra, input logic [7:0] d);
        bus.cpu_addr = {3'b001, ra};
        bus.ram_a    = ra;
        bus.cpu_dout = d;
        bus.mem_wr   = 1'b1;
        tick(1);
        bus.mem_wr = 1'b0;
        tick(1);
    endtask

    task automatic ram_read(input string tag, input logic [RAM_AW-1:0] ra, input logic [7:0] exp);
        rd_exp_t e;
        bus.cpu_addr = {3'b001, ra};
        bus.ram_a    = ra;
        bus.mem_rd   = 1'b1;
        sb_q.push_back('{tag, exp});
        tick(1);
        if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, 16'(bus.dout), 16'(e.exp));
        end
        bus.mem_rd = 1'b0;
    endtask

    initial begin
        int cycles;
        reset        = 1'b1;
        bus.cpu_addr = '0;
        bus.cpu_dout = '0;
        bus.m1       = 1'b0;
        bus.io_wr    = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.ram_a    = '0;
        bus.key_nmi  = 1'b0;
        tick(3);
        bus.cpu_addr = 16'h2000;
        bus.mem_rd   = 1'b1;
        #1;
        check("rst_state", 16'(bus.state), 16'd0);
        check("rst_nmi", 16'(bus.nmi), 16'd0);
        check("rst_ram_en", 16'(bus.mf_ram_en), 16'd0);
        check("rst_dout", 16'(bus.dout), 16'h00FF);
        bus.cpu_addr = 16'h0000;
        #1;
        check("rst_rom_en", 16'(bus.mf_rom_en), 16'd0);
        bus.mem_rd = 1'b0;
        reset      = 1'b0;
        tick(2);

        // Hotkey: nmi appears two edges after the key is first driven.
        bus.key_nmi = 1'b1;
        tick(1);
        check("nmi_early", 16'(bus.nmi), 16'd0);
        bus.key_nmi = 1'b0;
        tick(1);
        check("nmi_set", 16'(bus.nmi), 16'd1);
        check("pend_state", 16'(bus.state), 16'd1);

        fetch(16'h0066);
        check("ack_state", 16'(bus.state), 16'd2);
        check("ack_nmi", 16'(bus.nmi), 16'd0);
        bus.cpu_addr = 16'h0000;
        bus.mem_rd   = 1'b1;
        #1;
        check("rom_en", 16'(bus.mf_rom_en), 16'd1);
        check("rom_dout", 16'(bus.dout), 16'h00FF);
        bus.mem_rd = 1'b0;

        ram_write(13'h0010, 8'hA5);
        bus.cpu_addr = 16'h2010;
        #1;
        check("ram_en", 16'(bus.mf_ram_en), 16'd1);
        check("ram_rom_en", 16'(bus.mf_rom_en), 16'd0);
        check("ram_no_rd", 16'(bus.dout), 16'h00FF);
        ram_read("ram_a5", 13'h0010, 8'hA5);
        ram_write(13'h0011, 8'h3C);
        ram_read("ram_3c", 13'h0011, 8'h3C);
        ram_read("ram_a5_keep", 13'h0010, 8'hA5);

        io_out(16'h7F00, 8'h02);
        io_out(16'h7F00, 8'h4C);
        ram_read("ga_pen_sel", 13'h1FCF, 8'h02);
        ram_read("ga_ink2", 13'h1F92, 8'h4C);
        io_out(16'h7F00, 8'h10);
        io_out(16'h7F00, 8'h54);
        ram_read("ga_border", 13'h1FDF, 8'h54);
        io_out(16'h7F00, 8'h80);
        ram_read("ga_mode", 13'h1FEF, 8'h80);
        io_out(16'h7F00, 8'hC3);
        ram_read("ga_mmr", 13'h1FFF, 8'hC3);

        io_out(16'hBC00, 8'h0C);
        io_out(16'hBD00, 8'h30);
        ram_read("crtc_idx", 13'h1CFF, 8'h0C);
        ram_read("crtc_r12", 13'h1DBC, 8'h30);
        io_out(16'hBC00, 8'h1C);
        io_out(16'hBD00, 8'h77);
        ram_read("crtc_idx_raw", 13'h1CFF, 8'h1C);
        ram_read("crtc_bit4_ign", 13'h1DBC, 8'h77);
        io_out(16'hDF00, 8'h07);
        ram_read("romsel", 13'h1AAC, 8'h07);

        io_out(16'hFEEA, 8'h00);
        check("pageout", 16'(bus.state), 16'd3);
        bus.cpu_addr = 16'h0000;
        #1;
        check("pageout_rom", 16'(bus.mf_rom_en), 16'd0);
        io_out(16'hFEE8, 8'h00);
        check("pagein", 16'(bus.state), 16'd2);

        fetch(16'h0065);
        check("hid_paged", 16'(bus.state), 16'd4);
        io_out(16'hFEE8, 8'h00);
        check("hidden", 16'(bus.state), 16'd5);
        io_out(16'hF700, 8'h5A);
        io_out(16'hFEE8, 8'h00);
        check("hidden_stay", 16'(bus.state), 16'd5);
        bus.cpu_addr = 16'h0000;
        #1;
        check("hidden_rom", 16'(bus.mf_rom_en), 16'd0);
        key_pulse();
        check("hidden_key", 16'(bus.state), 16'd1);
        fetch(16'h0066);
        check("reack", 16'(bus.state), 16'd2);
        ram_read("ppi_hidden", 13'h17FF, 8'h5A);

        key_pulse();
        check("paged_key_nmi", 16'(bus.nmi), 16'd0);
        check("paged_key_st", 16'(bus.state), 16'd2);

        // Timeout: nmi must fall roughly 100 cycles after PEND entry, back to UNPAGED.
        io_out(16'hFEEA, 8'h00);
        key_pulse();
        check("tmo_pend", 16'(bus.nmi), 16'd1);
        cycles = 0;
        while (bus.nmi === 1'b1 && cycles < 300) begin
            tick(1);
            cycles++;
        end
        check("tmo_len", 16'(cycles >= 100 && cycles <= 102), 16'd1);
        check("tmo_state", 16'(bus.state), 16'd3);

        key_pulse();
        check("pre_rst_nmi", 16'(bus.nmi), 16'd1);
        reset = 1'b1;
        #1;
        check("async_nmi", 16'(bus.nmi), 16'd0);
        check("async_state", 16'(bus.state), 16'd0);
        tick(2);
        reset = 1'b0;
        tick(1);

        check("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/multiface_ctl.md
# multiface_ctl

Parametrised Multiface-style freezer controller for the CPC core: turns a hotkey edge into a Z80 NMI, pages its own ROM window and internal RAM over the low 16 KB while active, and shadows write-only hardware registers (gate array, CRTC, PPI, ROM select) into that RAM so freezer software can read them back. It sits between the motherboard CPU bus and the SDRAM controller. Generalises RAM depth, CRTC register count and the control-port address, and adds an NMI-acknowledge timeout and a status output.

## Interface
- RAM_AW, 13: internal RAM address width (2^RAM_AW bytes, must be ≥13).
- CRTC_REGS, 16: shadowed CRTC registers (16 or 32).
- CTRL_PORT, 16'hFEE8: page-in port; CTRL_PORT|2 is page-out. Bits [1:0] of CTRL_PORT are 0.
- NMI_TIMEOUT, 0: clk_sys cycles to wait for NMI acknowledge (0 = wait forever).

- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  16  CPU address bus.
- cpu_dout  in  8  CPU write data.
- m1  in  1  opcode fetch strobe.
- io_wr  in  1  I/O write strobe.
- mem_rd / mem_wr  in  1 each  memory read/write strobes.
- ram_a  in  RAM_AW  mapped memory address (low bits used for RAM window).
- key_nmi  in  1  freeze hotkey.
- nmi  out  1  NMI request to CPU.
- mf_rom_en  out  1  paged and cpu_addr[15:13]==0; steers SDRAM to MF ROM, blocks write.
- mf_ram_en  out  1  paged and cpu_addr[15:13]==1; blocks SDRAM access.
- dout  out  8  read data; 8'hFF unless mf_ram_en & mem_rd.
- state  out  3  encoded FSM state (debug/LED).

## Operation
- States: IDLE(0), PEND(1), PAGED(2), UNPAGED(3), HID_PAGED(4), HIDDEN(5). Paged = PAGED or HID_PAGED.
- Rising key_nmi in IDLE, UNPAGED or HIDDEN -> PEND, nmi=1; ignored when paged or in PEND.
- PEND: rising m1 with cpu_addr==16'h0066 -> PAGED, nmi=0. If NMI_TIMEOUT>0 and counter reaches NMI_TIMEOUT -> return to entry state, nmi=0.
- PAGED: rising m1 with cpu_addr==16'h0065 -> HID_PAGED.
- Rising io_wr, cpu_addr[15:2]==CTRL_PORT[15:2]: bit1=0 -> PAGED from PAGED/UNPAGED; bit1=1 -> UNPAGED from PAGED. From HID_PAGED either port -> HIDDEN. In HIDDEN/IDLE/PEND ports ignored.
- Shadow capture on rising io_wr (not ctrl port), offsets within top 8 KB (upper RAM_AW-13 address bits all ones):
  - 7Fxx data[7:6]=00: 1FCF, latch pen index data[4:0]; =01: pen[4] ? 1FDF : 1F90+pen[3:0]; =10: 1FEF; =11: 1FFF.
  - BCxx: 1CFF, latch CRTC index data[4:0] (bit4 ignored when CRTC_REGS=16); BDxx: 1DB0+index.
  - F7xx: 17FF; DFxx: 1AAC. Capture occurs in every state.
- Port priority same cycle: ctrl port > shadow capture > CPU RAM write (mf_ram_en & mem_wr at ram_a low bits) > read.
- RAM write-through: written byte appears on the read register next cycle.

## Timing
- Reset (async): state=IDLE, nmi=0, pen/CRTC index=0, timeout counter=0, write enable=0; mf_rom_en=mf_ram_en=0, dout=8'hFF. RAM contents undefined.
- Edge detectors (key_nmi, m1, io_wr) register one cycle; state changes one cycle after the sampled rising edge.
- mf_rom_en/mf_ram_en combinational from state and cpu_addr.
- RAM read: address registered at cycle N, data valid N+1; dout combinational select.
- Timeout counter counts from PEND entry; clears on exit.
- Reset asserted in PEND drops nmi immediately (async).

## Test plan
- Reset, pulse key_nmi -> nmi=1 next+1 cycle; m1 edge at 0066 -> nmi=0, state=2, cpu read 0000 gives mf_rom_en=1.
- Paged: write 8'hA5 to 2010 -> read 2010 returns A5 with mf_ram_en=1, SDRAM write blocked.
- OUT 7F00,02 then OUT 7F00,4C -> RAM[1F92]=4C; OUT BC00,0C, OUT BD00,30 -> RAM[1DBC]=30.
- m1 at 0065 then OUT FEE8 -> state=5; later OUT FEE8 -> stays 5, mf_rom_en=0; key_nmi -> state=1.
- NMI_TIMEOUT=100, key_nmi, no 0066 fetch -> nmi drops after 100 cycles, state returns to entry.
- key_nmi edge while PAGED -> nmi stays 0; reset during PEND -> nmi=0 same cycle, state=0.
